// File: rtl/uart_peak_request_responder_if.sv
// -----------------------------------------------------------------------------
// uart_peak_request_responder_if
//   Bundles the responder's control of the test datapath and its byte
//   handshake into the UART transmitter.
//
//   Signals
//     Channel_sel      [7:0]  datapath channel select (1..NUM_CHANNELS)
//     Hold_Data_sel           1 = datapath holds its send register
//     Byte_To_Send_sel        1 = high byte, 0 = low byte on Word_To_Send
//     tx_valid                byte on Word_To_Send is offered to the transmitter
//     tx_ready                transmitter can take the offered byte
//
//   Handshake: a byte transfers on every rising clk edge where tx_valid and
//   tx_ready are both 1. Once tx_valid rises it stays high, and
//   Byte_To_Send_sel / Hold_Data_sel / Channel_sel stay constant, until that
//   transfer happens. tx_ready may change freely and is ignored while
//   tx_valid is 0.
//
//   Modports
//     master  responder side (drives the controls and tx_valid)
//     slave   datapath / transmitter side (drives tx_ready)
// -----------------------------------------------------------------------------
interface uart_peak_request_responder_if;
  logic [7:0] Channel_sel;
  logic       Hold_Data_sel;
  logic       Byte_To_Send_sel;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output Channel_sel,
    output Hold_Data_sel,
    output Byte_To_Send_sel,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  Channel_sel,
    input  Hold_Data_sel,
    input  Byte_To_Send_sel,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_peak_request_responder.sv
// -----------------------------------------------------------------------------
// uart_peak_request_responder
//   Host-facing end of the pool-test peak-readout link. An 8N1 UART receiver
//   turns the host line into request bytes; each legal request (1..NUM_CHANNELS)
//   selects a datapath channel, lets the datapath capture its peak for one
//   cycle, then hands the high and low bytes of that peak to the transmitter.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UART bit (>= 4, even)
//     NUM_CHANNELS  highest legal request byte value
//
//   Ports
//     clk              in   system clock, all logic on posedge
//     reset_b          in   asynchronous active-low reset
//     uart_rx_serial   in   raw asynchronous RX line, idle high
//     rx_byte          out  last good received byte
//     rx_byte_valid    out  1-cycle pulse, rx_byte updated this cycle
//     framing_error    out  1-cycle pulse, stop bit sampled low
//     bad_cmd          out  1-cycle pulse, request byte out of range
//     cmd_overrun      out  1-cycle pulse, request dropped while busy
//     tx_if            master modport: channel/hold/byte select + tx handshake
//     o_dbg_rx_state   out  current RX FSM state
//     o_dbg_tx_state   out  current TX FSM state
// -----------------------------------------------------------------------------
module uart_peak_request_responder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         reset_b,
  input  logic                         uart_rx_serial,
  output logic [7:0]                   rx_byte,
  output logic                         rx_byte_valid,
  output logic                         framing_error,
  output logic                         bad_cmd,
  output logic                         cmd_overrun,
  uart_peak_request_responder_if.master tx_if,
  output logic [1:0]                   o_dbg_rx_state,
  output logic [1:0]                   o_dbg_tx_state
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    CH_MAX    = 8'(NUM_CHANNELS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_CAPTURE, T_SEND_HI, T_SEND_LO} tx_state_t;

  // ---------------------------------------------------------------------------
  // RX line synchroniser (resets to the idle-high level)
  // ---------------------------------------------------------------------------
  logic r_rx_meta, r_rx_sync;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_serial;
      r_rx_sync <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_t     r_rx_state, w_rx_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [7:0]    r_rx_byte, w_rx_byte_nx;
  logic          r_rx_valid, w_rx_valid_nx;
  logic          r_ferr, w_ferr_nx;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_rx_state <= R_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_baud     <= w_baud_nx;
      r_bit      <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_rx_byte  <= w_rx_byte_nx;
      r_rx_valid <= w_rx_valid_nx;
      r_ferr     <= w_ferr_nx;
    end
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_baud_nx     = r_baud;
    w_bit_nx      = r_bit;
    w_shift_nx    = r_shift;
    w_rx_byte_nx  = r_rx_byte;
    w_rx_valid_nx = 1'b0;
    w_ferr_nx     = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        w_baud_nx = '0;
        w_bit_nx  = '0;
        if (!r_rx_sync) w_rx_state_nx = R_START;
      end
      R_START: begin
        // Half a bit in: still low means a real start bit, high was a glitch.
        if (r_baud == HALF_LAST) begin
          w_baud_nx     = '0;
          w_rx_state_nx = r_rx_sync ? R_IDLE : R_DATA;
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      R_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nx  = '0;
          w_shift_nx = {r_rx_sync, r_shift[7:1]};   // LSB arrives first
          w_bit_nx   = r_bit + 1'b1;                 // wraps 7 -> 0
          if (r_bit == 3'd7) w_rx_state_nx = R_STOP;
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      R_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nx     = '0;
          w_rx_state_nx = R_IDLE;   // leave mid-stop so the next start edge is seen
          if (r_rx_sync) begin
            w_rx_byte_nx  = r_shift;
            w_rx_valid_nx = 1'b1;
          end else begin
            w_ferr_nx = 1'b1;
          end
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      default: w_rx_state_nx = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TX FSM: reacts to each registered rx_byte_valid pulse
  // ---------------------------------------------------------------------------
  tx_state_t  r_tx_state, w_tx_state_nx;
  logic [7:0] r_ch, w_ch_nx;
  logic       r_hold, r_bsel, r_tx_valid;
  logic       w_hold_nx, w_bsel_nx, w_tx_valid_nx;
  logic       r_bad, w_bad_nx;
  logic       r_ovr, w_ovr_nx;
  logic       w_accept;
  logic       w_in_range;

  assign w_accept   = r_tx_valid & tx_if.tx_ready;
  assign w_in_range = (r_rx_byte >= 8'd1) && (r_rx_byte <= CH_MAX);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_tx_state <= T_IDLE;
      r_ch       <= 8'd1;
      r_hold     <= 1'b0;
      r_bsel     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_bad      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_ch       <= w_ch_nx;
      r_hold     <= w_hold_nx;
      r_bsel     <= w_bsel_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_bad      <= w_bad_nx;
      r_ovr      <= w_ovr_nx;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_ch_nx       = r_ch;
    w_bad_nx      = 1'b0;
    w_ovr_nx      = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (r_rx_valid) begin
          if (w_in_range) begin
            w_ch_nx       = r_rx_byte;
            w_tx_state_nx = T_CAPTURE;
          end else begin
            w_bad_nx = 1'b1;
          end
        end
      end
      T_CAPTURE: w_tx_state_nx = T_SEND_HI;
      T_SEND_HI: if (w_accept) w_tx_state_nx = T_SEND_LO;
      T_SEND_LO: if (w_accept) w_tx_state_nx = T_IDLE;
      default:   w_tx_state_nx = T_IDLE;
    endcase
    // A busy responder drops the request; busy takes priority over range.
    if (r_rx_valid && (r_tx_state != T_IDLE)) w_ovr_nx = 1'b1;
    // Outputs are registered decodes of the state being entered, so they
    // line up exactly with the state register.
    w_tx_valid_nx = (w_tx_state_nx == T_SEND_HI) || (w_tx_state_nx == T_SEND_LO);
    w_hold_nx     = w_tx_valid_nx;
    w_bsel_nx     = (w_tx_state_nx == T_SEND_HI);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_byte                = r_rx_byte;
  assign rx_byte_valid          = r_rx_valid;
  assign framing_error          = r_ferr;
  assign bad_cmd                = r_bad;
  assign cmd_overrun            = r_ovr;
  assign tx_if.Channel_sel      = r_ch;
  assign tx_if.Hold_Data_sel    = r_hold;
  assign tx_if.Byte_To_Send_sel = r_bsel;
  assign tx_if.tx_valid         = r_tx_valid;
  assign o_dbg_rx_state         = r_rx_state;
  assign o_dbg_tx_state         = r_tx_state;

endmodule

// File: tb/tb_uart_peak_request_responder.sv
module tb_uart_peak_request_responder;
  localparam int CPB = 16;
  localparam int NCH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic uart_rx_serial = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_byte;
  logic       rx_byte_valid, framing_error, bad_cmd, cmd_overrun;
  logic [1:0] dbg_rx_state, dbg_tx_state;

  uart_peak_request_responder_if tx_if();

  uart_peak_request_responder #(.CLKS_PER_BIT(CPB), .NUM_CHANNELS(NCH)) dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .uart_rx_serial (uart_rx_serial),
    .rx_byte        (rx_byte),
    .rx_byte_valid  (rx_byte_valid),
    .framing_error  (framing_error),
    .bad_cmd        (bad_cmd),
    .cmd_overrun    (cmd_overrun),
    .tx_if          (tx_if.master),
    .o_dbg_rx_state (dbg_rx_state),
    .o_dbg_tx_state (dbg_tx_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_rx_q[$];
  logic [8:0] exp_q[$];        // {Byte_To_Send_sel, Channel_sel} per accepted byte
  logic [7:0] exp_ch      = 8'd1;
  logic [7:0] exp_last_rx = 8'd0;

  // Observations collected at negedge
  logic [7:0] got_rx_q[$];
  logic [8:0] got_acc_q[$];
  logic [2:0] trace_q[$];      // {tx_valid, Byte_To_Send_sel, Hold_Data_sel} after a request
  int         trace_left = 0;
  int         n_ferr = 0, n_bad = 0, n_ovr = 0, n_viol = 0;
  logic       prev_pend = 1'b0;
  logic       prev_bs = 1'b0;
  logic [7:0] prev_ch = 8'd0;

  always @(negedge clk) begin
    if (!reset_b) begin
      prev_pend  = 1'b0;
      trace_left = 0;
    end else begin
      if (trace_left > 0) begin
        trace_q.push_back({tx_if.tx_valid, tx_if.Byte_To_Send_sel, tx_if.Hold_Data_sel});
        trace_left--;
      end
      if (rx_byte_valid) begin
        got_rx_q.push_back(rx_byte);
        trace_q.delete();
        trace_left = 4;
      end
      if (framing_error) n_ferr++;
      if (bad_cmd)       n_bad++;
      if (cmd_overrun)   n_ovr++;
      // An offered byte must not change or vanish before it is taken.
      if (prev_pend && (tx_if.tx_valid !== 1'b1 || tx_if.Byte_To_Send_sel !== prev_bs ||
                        tx_if.Hold_Data_sel !== 1'b1 || tx_if.Channel_sel !== prev_ch))
        n_viol++;
      if (tx_if.tx_valid && tx_if.tx_ready)
        got_acc_q.push_back({tx_if.Byte_To_Send_sel, tx_if.Channel_sel});
      prev_pend = tx_if.tx_valid && !tx_if.tx_ready;
      prev_bs   = tx_if.Byte_To_Send_sel;
      prev_ch   = tx_if.Channel_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: what one request byte should do when the responder is idle
  // ---------------------------------------------------------------------------
  task automatic model_request(input logic [7:0] b);
    exp_rx_q.push_back(b);
    exp_last_rx = b;
    if (b >= 8'd1 && b <= 8'(NCH)) begin
      exp_ch = b;
      exp_q.push_back({1'b1, b});
      exp_q.push_back({1'b0, b});
    end
  endtask

  task automatic clear_logs();
    got_rx_q.delete();
    got_acc_q.delete();
    exp_rx_q.delete();
    exp_q.delete();
    n_ferr = 0; n_bad = 0; n_ovr = 0; n_viol = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 uart_rx_serial = f[i];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 uart_rx_serial = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    exp_ch = 8'd1;
    exp_last_rx = 8'd0;
    repeat (2) @(posedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_b = 1'b0;
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1 uart_rx_serial = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (rx_byte !== 8'd0) begin
        n_fail++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte);
      end
      n_cmp++;
      if (tx_if.Channel_sel !== 8'd1) begin
        n_fail++; $display("FAIL reset_channel: got %h want 01", tx_if.Channel_sel);
      end
      n_cmp++;
      if ({rx_byte_valid, framing_error, bad_cmd, cmd_overrun, tx_if.tx_valid,
           tx_if.Hold_Data_sel, tx_if.Byte_To_Send_sel} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_flags: got %b want 0000000", {rx_byte_valid, framing_error,
                 bad_cmd, cmd_overrun, tx_if.tx_valid, tx_if.Hold_Data_sel, tx_if.Byte_To_Send_sel});
      end
    end
    @(posedge clk); #1 uart_rx_serial = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset_b = 1'b1;
    repeat (40) @(posedge clk);
    n_cmp++;
    if (got_rx_q.size() != 0 || n_ferr != 0) begin
      n_fail++; $display("FAIL reset_quiet: got rx=%0d ferr=%0d want 0 0", got_rx_q.size(), n_ferr);
    end
  endtask

  task automatic test_single();
    logic [2:0] exp_tr[4];
    clear_logs();
    tx_if.tx_ready = 1'b1;
    model_request(8'h03);
    send_frame(8'h03, 1'b1);
    repeat (10) @(posedge clk);
    exp_tr = '{3'b000, 3'b111, 3'b101, 3'b000};  // capture, HI, LO, idle
    n_cmp++;
    if (got_rx_q.size() != 1 || got_rx_q[0] !== 8'h03) begin
      n_fail++; $display("FAIL single_rx: got n=%0d byte=%h want n=1 byte=03",
                         got_rx_q.size(), (got_rx_q.size() > 0) ? got_rx_q[0] : 8'hxx);
    end
    n_cmp++;
    if (tx_if.Channel_sel !== exp_ch) begin
      n_fail++; $display("FAIL single_channel: got %h want %h", tx_if.Channel_sel, exp_ch);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (trace_q.size() != 4 || trace_q[i] !== exp_tr[i]) begin
        n_fail++; $display("FAIL single_trace[%0d]: got %b (n=%0d) want %b", i,
                           (trace_q.size() > i) ? trace_q[i] : 3'bxxx, trace_q.size(), exp_tr[i]);
      end
    end
    n_cmp++;
    if (got_acc_q != exp_q) begin
      n_fail++; $display("FAIL single_accepts: got n=%0d want n=%0d", got_acc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    int k;
    clear_logs();
    tx_if.tx_ready = 1'b0;
    model_request(8'h01);
    send_frame(8'h01, 1'b1);
    k = 0;
    while (!tx_if.tx_valid && k < 50) begin @(negedge clk); k++; end
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n_cmp++;
        if ({tx_if.tx_valid, tx_if.Byte_To_Send_sel, tx_if.Hold_Data_sel} !== {1'b1, (s == 0), 1'b1}) begin
          n_fail++; $display("FAIL bp_hold_s%0d_c%0d: got %b want %b", s, i,
                             {tx_if.tx_valid, tx_if.Byte_To_Send_sel, tx_if.Hold_Data_sel}, {1'b1, (s == 0), 1'b1});
        end
      end
      @(posedge clk); #1 tx_if.tx_ready = 1'b1;
      @(posedge clk); #1 tx_if.tx_ready = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (tx_if.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_done: got tx_valid=%b want 0", tx_if.tx_valid);
    end
    n_cmp++;
    if (got_acc_q != exp_q) begin
      n_fail++; $display("FAIL bp_accepts: got n=%0d want n=%0d", got_acc_q.size(), exp_q.size());
    end
    n_cmp++;
    if (n_viol != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d violations want 0", n_viol);
    end
  endtask

  task automatic test_framing();
    clear_logs();
    tx_if.tx_ready = 1'b1;
    send_frame(8'h02, 1'b0);
    repeat (30) @(posedge clk);
    @(posedge clk); #1 uart_rx_serial = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx_serial = 1'b1;
    repeat (60) @(posedge clk);
    n_cmp++;
    if (n_ferr != 1) begin
      n_fail++; $display("FAIL framing_pulse: got %0d want 1", n_ferr);
    end
    n_cmp++;
    if (got_rx_q.size() != 0 || rx_byte !== exp_last_rx) begin
      n_fail++; $display("FAIL framing_rx: got n=%0d byte=%h want n=0 byte=%h",
                         got_rx_q.size(), rx_byte, exp_last_rx);
    end
    n_cmp++;
    if (got_acc_q.size() != 0 || tx_if.Channel_sel !== exp_ch || n_bad != 0) begin
      n_fail++; $display("FAIL framing_quiet: got acc=%0d ch=%h bad=%0d want 0 %h 0",
                         got_acc_q.size(), tx_if.Channel_sel, n_bad, exp_ch);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] bytes[4];
    do_reset();
    clear_logs();
    tx_if.tx_ready = 1'b1;
    bytes = '{8'h00, 8'h07, 8'h05, 8'h04};
    for (int i = 0; i < 3; i++) begin
      model_request(bytes[i]);
      send_frame(bytes[i], 1'b1);
      repeat (4) @(posedge clk);
      n_cmp++;
      if (tx_if.Channel_sel !== 8'd1) begin
        n_fail++; $display("FAIL bad_channel[%0d]: got %h want 01", i, tx_if.Channel_sel);
      end
    end
    n_cmp++;
    if (n_bad != 3 || got_acc_q.size() != 0) begin
      n_fail++; $display("FAIL bad_count: got bad=%0d acc=%0d want 3 0", n_bad, got_acc_q.size());
    end
    model_request(bytes[3]);
    send_frame(bytes[3], 1'b1);
    repeat (8) @(posedge clk);
    n_cmp++;
    if (tx_if.Channel_sel !== exp_ch || got_acc_q != exp_q || n_bad != 3) begin
      n_fail++; $display("FAIL top_channel: got ch=%h acc=%0d bad=%0d want %h %0d 3",
                         tx_if.Channel_sel, got_acc_q.size(), n_bad, exp_ch, exp_q.size());
    end
    n_cmp++;
    if (got_rx_q != exp_rx_q) begin
      n_fail++; $display("FAIL bad_rx_bytes: got n=%0d want n=%0d", got_rx_q.size(), exp_rx_q.size());
    end
  endtask

  task automatic test_overrun();
    int k;
    clear_logs();
    tx_if.tx_ready = 1'b0;
    model_request(8'h03);
    send_frame(8'h03, 1'b1);
    k = 0;
    while (!tx_if.tx_valid && k < 50) begin @(negedge clk); k++; end
    send_frame(8'h02, 1'b1);   // busy, in range
    send_frame(8'h09, 1'b1);   // busy and out of range: overrun only
    @(negedge clk);
    n_cmp++;
    if (n_ovr != 2 || n_bad != 0) begin
      n_fail++; $display("FAIL overrun_pulses: got ovr=%0d bad=%0d want 2 0", n_ovr, n_bad);
    end
    n_cmp++;
    if (tx_if.Channel_sel !== 8'h03 || rx_byte !== 8'h09) begin
      n_fail++; $display("FAIL overrun_state: got ch=%h rx=%h want 03 09", tx_if.Channel_sel, rx_byte);
    end
    @(posedge clk); #1 tx_if.tx_ready = 1'b1;
    @(posedge clk); #1 tx_if.tx_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tx_if.tx_valid, tx_if.Byte_To_Send_sel} !== 2'b10) begin
      n_fail++; $display("FAIL overrun_lo: got %b want 10", {tx_if.tx_valid, tx_if.Byte_To_Send_sel});
    end
    #2 reset_b = 1'b0;
    #1;
    n_cmp++;
    if ({tx_if.tx_valid, tx_if.Hold_Data_sel, tx_if.Channel_sel} !== {2'b00, 8'd1}) begin
      n_fail++; $display("FAIL async_reset: got valid=%b hold=%b ch=%h want 0 0 01",
                         tx_if.tx_valid, tx_if.Hold_Data_sel, tx_if.Channel_sel);
    end
    n_cmp++;
    if (got_acc_q.size() != 1 || got_acc_q[0] !== 9'h103 || n_viol != 0) begin
      n_fail++; $display("FAIL overrun_accepts: got n=%0d viol=%0d want n=1 viol=0", got_acc_q.size(), n_viol);
    end
    @(posedge clk); #1 reset_b = 1'b1;
    exp_ch = 8'd1;
    exp_last_rx = 8'd0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int k;
    clear_logs();
    for (int n = 0; n < 12; n++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      model_request(b);
      tx_if.tx_ready = 1'($urandom_range(0, 1));
      send_frame(b, 1'b1);
      k = 0;
      while (got_acc_q.size() < exp_q.size() && k < 400) begin
        @(posedge clk); #1 tx_if.tx_ready = 1'($urandom_range(0, 1));
        k++;
      end
      n_cmp++;
      if (got_acc_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand_timeout[%0d]: got %0d accepts want %0d", n, got_acc_q.size(), exp_q.size());
      end
      repeat (3) @(posedge clk);
    end
    for (int i = 0; i < exp_rx_q.size(); i++) begin
      n_cmp++;
      if (i >= got_rx_q.size() || got_rx_q[i] !== exp_rx_q[i]) begin
        n_fail++; $display("FAIL rand_rx[%0d]: got %h want %h", i,
                           (i < got_rx_q.size()) ? got_rx_q[i] : 8'hxx, exp_rx_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_acc_q.size() || got_acc_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_acc[%0d]: got %h want %h", i,
                           (i < got_acc_q.size()) ? got_acc_q[i] : 9'hxxx, exp_q[i]);
      end
    end
    n_cmp++;
    if (tx_if.Channel_sel !== exp_ch || n_viol != 0 || n_ovr != 0) begin
      n_fail++; $display("FAIL rand_final: got ch=%h viol=%0d ovr=%0d want %h 0 0",
                         tx_if.Channel_sel, n_viol, n_ovr, exp_ch);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    tx_if.tx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_framing();
    test_bad_cmd();
    test_overrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
